// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver running on the system clock.
// Input pins are synchronised and run-length filtered. Each falling edge of the
// filtered keyboard clock strobes in one bit. Complete frames are checked for
// start, parity and stop. E0/F0 prefixes are folded into make/break events,
// which are queued in a small FIFO with a valid/ready interface.
module ps2_key_event_rx #(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_e;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic [FW-1:0] clk_cnt_q, dat_cnt_q;
  logic          clk_filt_q, dat_filt_q, clk_prev_q;
  logic          clk_fall_s;

  state_e        state_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          frame_err_q;
  logic          byte_stb_q;
  logic [7:0]    byte_q;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [8:0]    last_q, last_d;
  logic          last_vld_q, last_vld_d;
  logic          push_s;
  logic [9:0]    push_data_s;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          full_s, pop_s, wr_en_s, drop_s;

  // Two-stage synchronisers and run-length glitch filters for both pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DATA};
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        clk_cnt_q <= '0;
      end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        clk_cnt_q  <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + FW'(1);
      end
      if (dat_sync_q[1] == dat_filt_q) begin
        dat_cnt_q <= '0;
      end else if (dat_cnt_q == FW'(FILTER_LEN - 1)) begin
        dat_filt_q <= dat_sync_q[1];
        dat_cnt_q  <= '0;
      end else begin
        dat_cnt_q <= dat_cnt_q + FW'(1);
      end
    end
  end

  assign clk_fall_s = clk_prev_q & ~clk_filt_q;

  // Frame FSM: collects start/data/parity/stop bits, validates, and times out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= 8'd0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'd0;
    end else begin
      frame_err_q <= 1'b0;
      byte_stb_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (clk_fall_s && !dat_filt_q) begin
            state_q  <= RECV;
            bitcnt_q <= 4'd1;
          end
        end
        RECV: begin
          if (clk_fall_s) begin
            tmo_q <= '0;
            if (bitcnt_q <= 4'd8) begin
              shreg_q  <= {dat_filt_q, shreg_q[7:1]};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
              parity_q <= dat_filt_q;
              bitcnt_q <= bitcnt_q + 4'd1;
            end else begin
              // Stop bit: odd parity over data+parity and a high stop bit.
              if (((^shreg_q) ^ parity_q) && dat_filt_q) begin
                byte_stb_q <= 1'b1;
                byte_q     <= shreg_q;
              end else begin
                frame_err_q <= 1'b1;
              end
              state_q  <= IDLE;
              bitcnt_q <= 4'd0;
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          bitcnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Prefix decoder and typematic-repeat filter, evaluated on the byte strobe.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    push_s      = 1'b0;
    push_data_s = {brk_q, ext_q, byte_q};
    if (byte_stb_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          last_vld_d = 1'b0;
          push_s     = 1'b1;
        end else if ((SUPPRESS_REPEAT != 0) && last_vld_q && (last_q == {ext_q, byte_q})) begin
          push_s = 1'b0;
        end else begin
          push_s     = 1'b1;
          last_d     = {ext_q, byte_q};
          last_vld_d = 1'b1;
        end
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign pop_s   = evt_valid & evt_ready;
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Occupancy update from the push/pop combination.
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Decoder state, FIFO storage/pointers and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      last_q     <= 9'd0;
      last_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      count_q    <= count_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= push_data_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: three instances (repeat suppression on,
// off, and a 4-deep FIFO) share the PS/2 pins; a short timeout keeps runs small.
module tb_ps2_key_event_rx;
  localparam int H   = 20;
  localparam int TMO = 200;

  logic clk = 1'b0, rst = 1'b1, ps2c = 1'b1, ps2d = 1'b1, ovf_clr = 1'b0;
  logic ready_ab = 1'b1, ready_c_man = 1'b0, pop_on_push = 1'b0;
  logic rdy_c;
  logic [9:0] da, db, dc;
  logic va, vb, vc, fea, feb, fec, ova, ovb, ovc;
  logic [3:0] cnta, cntb;
  logic [2:0] cntc;

  always #5 clk = ~clk;

  ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8), .SUPPRESS_REPEAT(1)) u_a (
    .CLK(clk), .RST(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d), .evt_data(da), .evt_valid(va),
    .evt_ready(ready_ab), .fifo_count(cnta), .frame_err(fea), .overflow(ova), .ovf_clr(ovf_clr));
  ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8), .SUPPRESS_REPEAT(0)) u_b (
    .CLK(clk), .RST(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d), .evt_data(db), .evt_valid(vb),
    .evt_ready(ready_ab), .fifo_count(cntb), .frame_err(feb), .overflow(ovb), .ovf_clr(ovf_clr));
  ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .SUPPRESS_REPEAT(1)) u_c (
    .CLK(clk), .RST(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d), .evt_data(dc), .evt_valid(vc),
    .evt_ready(rdy_c), .fifo_count(cntc), .frame_err(fec), .overflow(ovc), .ovf_clr(ovf_clr));

  // Consumer C pops either on demand or exactly in a cycle when an event is pushed.
  assign rdy_c = ready_c_man | (pop_on_push & u_c.push_s);

  int n_vec = 0, n_err = 0;
  logic [9:0] qa[$], qb[$], qc[$];
  int erra = 0, cyc = 0, stop_cyc = -1, rise_cyc = -1;
  logic va_prev = 1'b0;

  // Collect popped events and error pulses, and timestamp the first stop strobe / valid rise.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (va && ready_ab) qa.push_back(da);
      if (vb && ready_ab) qb.push_back(db);
      if (vc && rdy_c) qc.push_back(dc);
      if (fea) erra++;
      if (u_a.clk_fall_s && u_a.bitcnt_q == 4'd10 && stop_cyc < 0) stop_cyc = cyc;
      if (va && !va_prev && rise_cyc < 0) rise_cyc = cyc;
    end
    va_prev = va;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    erra = 0; stop_cyc = -1; rise_cyc = -1;
    @(negedge clk);
  endtask

  // Drive the first nbits of an odd-parity frame; optional 3-cycle clock glitch after bit 3.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = fr[i];
      repeat (H / 2) @(negedge clk);
      ps2c = 1'b0;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
      repeat (15) @(negedge clk);
      if (glitch && i == 3) begin
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
      end
      repeat (H / 2) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11, 1'b0);
    repeat (30) @(negedge clk);
  endtask

  typedef struct packed {
    logic [7:0][7:0] bytes;
    logic [3:0]      nb;
    logic            glitch;
    logic [5:0][9:0] expa;
    logic [2:0]      nea;
    logic [5:0][9:0] expb;
    logic [2:0]      neb;
  } vec_t;

  vec_t vt [3];

  initial begin
    // Table: byte streams (index 0 sent first) and expected events for suppression on/off.
    vt[0].bytes = 64'h0000_0000_001C_F01C; vt[0].nb = 4'd3; vt[0].glitch = 1'b0;
    vt[0].expa  = {40'h0, 10'h21C, 10'h01C}; vt[0].nea = 3'd2;
    vt[0].expb  = {40'h0, 10'h21C, 10'h01C}; vt[0].neb = 3'd2;
    vt[1].bytes = 64'h0000_0075_F0E0_75E0; vt[1].nb = 4'd5; vt[1].glitch = 1'b1;
    vt[1].expa  = {40'h0, 10'h375, 10'h175}; vt[1].nea = 3'd2;
    vt[1].expb  = {40'h0, 10'h375, 10'h175}; vt[1].neb = 3'd2;
    vt[2].bytes = 64'h0000_1C1C_F01C_1C1C; vt[2].nb = 4'd6; vt[2].glitch = 1'b0;
    vt[2].expa  = {30'h0, 10'h01C, 10'h21C, 10'h01C}; vt[2].nea = 3'd3;
    vt[2].expb  = {10'h0, 10'h01C, 10'h21C, 10'h01C, 10'h01C, 10'h01C}; vt[2].neb = 3'd5;

    do_reset();
    check("rst_valid", {va, vc}, 2'b00);
    check("rst_data", {da, dc}, 20'h0);
    check("rst_count", {cnta, cntc}, 7'h0);
    check("rst_ferr_ovf", {fea, fec, ova, ovc}, 4'h0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int j = 0; j < int'(vt[v].nb); j++) begin
        send_bits(vt[v].bytes[j], 1'b0, 11, vt[v].glitch && (j == 1));
        repeat (30) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_a_count", v), qa.size(), vt[v].nea);
      for (int k = 0; k < int'(vt[v].nea); k++)
        check($sformatf("v%0d_a_evt%0d", v, k), (k < qa.size()) ? qa[k] : 10'h3FF, vt[v].expa[k]);
      check($sformatf("v%0d_b_count", v), qb.size(), vt[v].neb);
      for (int k = 0; k < int'(vt[v].neb); k++)
        check($sformatf("v%0d_b_evt%0d", v, k), (k < qb.size()) ? qb[k] : 10'h3FF, vt[v].expb[k]);
      check($sformatf("v%0d_no_ferr", v), erra, 0);
      if (v == 0) check("latency_stop_to_valid", rise_cyc - stop_cyc, 2);
    end

    // Bad parity frame then a good one.
    do_reset();
    send_bits(8'h1C, 1'b1, 11, 1'b0);
    repeat (30) @(negedge clk);
    send_byte(8'h1C);
    check("par_ferr_count", erra, 1);
    check("par_evt_count", qa.size(), 1);
    check("par_evt", (qa.size() > 0) ? qa[0] : 10'h3FF, 10'h01C);

    // Truncated frame, stall past the timeout, then a good frame.
    do_reset();
    send_bits(8'h24, 1'b0, 5, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_ferr_count", erra, 1);
    check("tmo_state_idle", {logic'(u_a.state_q), u_a.bitcnt_q}, 5'h0);
    send_byte(8'h24);
    check("tmo_evt_count", qa.size(), 1);
    check("tmo_evt", (qa.size() > 0) ? qa[0] : 10'h3FF, 10'h024);
    check("tmo_ferr_after", erra, 1);

    // 4-deep FIFO overflow, clear, full push-with-pop, drain.
    do_reset();
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
    send_byte(8'h2D); send_byte(8'h2C); send_byte(8'h35);
    check("ovf_count", cntc, 3'd4);
    check("ovf_flag", ovc, 1'b1);
    check("ovf_head", dc, 10'h015);
    check("ovf_no_pops", qc.size(), 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", ovc, 1'b0);
    pop_on_push = 1'b1;
    send_byte(8'h3C);
    pop_on_push = 1'b0;
    check("full_pushpop_count", cntc, 3'd4);
    check("full_pushpop_ovf", ovc, 1'b0);
    check("full_pushpop_popped", (qc.size() > 0) ? qc[0] : 10'h3FF, 10'h015);
    ready_c_man = 1'b1;
    repeat (10) @(negedge clk);
    ready_c_man = 1'b0;
    check("drain_total", qc.size(), 5);
    check("drain_1", (qc.size() > 1) ? qc[1] : 10'h3FF, 10'h01D);
    check("drain_2", (qc.size() > 2) ? qc[2] : 10'h3FF, 10'h024);
    check("drain_3", (qc.size() > 3) ? qc[3] : 10'h3FF, 10'h02D);
    check("drain_4", (qc.size() > 4) ? qc[4] : 10'h3FF, 10'h03C);
    check("drain_empty", {vc, cntc}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound in case the design never reaches the end of the sequence.
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
